// File: rtl/pads_out_seq.sv
// Output-pad front end: registers each core output once before the pad,
// brings channels up in staggered groups after reset to limit simultaneous
// switching, and offers hold / walking-one / force modes for bring-up.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   core_out   functional values from the core
//   mode       0=functional, 1=hold, 2=walk test, 3=force
//   force_val  values driven in force mode
//   pad_i      registered values to the pad cell I pins
//   en_mask    per-channel enable status (1 = channel live)
//   seq_done   all channels enabled
//   test_pos   current walking-one channel index
module pads_out_seq #(
    parameter int unsigned     NCH         = 9,
    parameter int unsigned     GROUP       = 2,
    parameter int unsigned     STAGGER_CYC = 4,
    parameter int unsigned     TEST_DIV    = 8,
    parameter logic [NCH-1:0]  RESET_VAL   = '0
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NCH-1:0]                         core_out,
    input  logic [1:0]                             mode,
    input  logic [NCH-1:0]                         force_val,
    output logic [NCH-1:0]                         pad_i,
    output logic [NCH-1:0]                         en_mask,
    output logic                                   seq_done,
    output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] test_pos
);

    localparam int unsigned TPW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned SCW    = (STAGGER_CYC > 1) ? $clog2(STAGGER_CYC) : 1;
    localparam int unsigned DVW    = (TEST_DIV > 1) ? $clog2(TEST_DIV) : 1;
    localparam int unsigned NSTEPS = (NCH + GROUP - 1) / GROUP;
    localparam int unsigned STW    = $clog2(NSTEPS + 1);

    localparam logic [1:0] MODE_FUNC  = 2'd0;
    localparam logic [1:0] MODE_HOLD  = 2'd1;
    localparam logic [1:0] MODE_WALK  = 2'd2;
    localparam logic [1:0] MODE_FORCE = 2'd3;

    typedef enum logic {
        ST_SEQ = 1'b0,
        ST_RUN = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [SCW-1:0]   scnt_q,  scnt_d;
    logic [STW-1:0]   step_q,  step_d;
    logic [NCH-1:0]   en_q,    en_d;
    logic             done_q,  done_d;
    logic [DVW-1:0]   div_q,   div_d;
    logic [TPW-1:0]   tp_q,    tp_d;
    logic [NCH-1:0]   pad_q,   pad_d;
    int unsigned      lim;

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_SEQ;
            scnt_q  <= '0;
            step_q  <= '0;
            en_q    <= '0;
            done_q  <= 1'b0;
            div_q   <= '0;
            tp_q    <= '0;
            pad_q   <= RESET_VAL;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
            step_q  <= step_d;
            en_q    <= en_d;
            done_q  <= done_d;
            div_q   <= div_d;
            tp_q    <= tp_d;
            pad_q   <= pad_d;
        end
    end

    // Stagger sequencer: one group of channels per STAGGER_CYC wrap, LSB first
    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        step_d  = step_q;
        en_d    = en_q;
        done_d  = done_q;
        lim     = (32'(step_q) + 32'd1) * GROUP;
        if (lim > NCH) begin
            lim = NCH;
        end

        if (state_q == ST_SEQ) begin
            if (scnt_q == SCW'(STAGGER_CYC - 1)) begin
                scnt_d = '0;
                step_d = step_q + STW'(1);
                for (int unsigned c = 0; c < NCH; c++) begin
                    if (c < lim) begin
                        en_d[c] = 1'b1;
                    end
                end
                if (lim == NCH) begin
                    state_d = ST_RUN;
                    done_d  = 1'b1;
                end
            end else begin
                scnt_d = scnt_q + SCW'(1);
            end
        end else begin
            en_d   = '1;
            done_d = 1'b1;
        end
    end

    // Walk divider and position; anything other than walk mode parks at channel 0
    always_comb begin
        div_d = '0;
        tp_d  = '0;
        if (mode == MODE_WALK) begin
            if (div_q == DVW'(TEST_DIV - 1)) begin
                div_d = '0;
                tp_d  = (tp_q == TPW'(NCH - 1)) ? '0 : tp_q + TPW'(1);
            end else begin
                div_d = div_q + DVW'(1);
                tp_d  = tp_q;
            end
        end
    end

    // Pad register source; gated by the enable mask being written this edge
    always_comb begin
        pad_d = pad_q;
        for (int unsigned c = 0; c < NCH; c++) begin
            if (!en_d[c]) begin
                pad_d[c] = RESET_VAL[c];
            end else begin
                case (mode)
                    MODE_FUNC:  pad_d[c] = core_out[c];
                    MODE_HOLD:  pad_d[c] = pad_q[c];
                    MODE_WALK:  pad_d[c] = (tp_q == TPW'(c));
                    MODE_FORCE: pad_d[c] = force_val[c];
                    default:    pad_d[c] = pad_q[c];
                endcase
            end
        end
    end

    assign pad_i    = pad_q;
    assign en_mask  = en_q;
    assign seq_done = done_q;
    assign test_pos = tp_q;

endmodule

// File: tb/tb_pads_out_seq.sv
// Directed bench for pads_out_seq: stagger bring-up, data latency / hold /
// force table, walking-one sweep, async reset mid-sequence, and a
// single-step GROUP=NCH, STAGGER_CYC=1 instance.
module tb_pads_out_seq;

    logic       clk;
    logic       rst;
    logic [8:0] core_out;
    logic [1:0] mode;
    logic [8:0] force_val;
    logic [1:0] mode_rv;
    logic [8:0] force_rv;

    logic [8:0] pad_a, en_a, pad_r, en_r, pad_o, en_o;
    logic       done_a, done_r, done_o;
    logic [3:0] tp_a, tp_r, tp_o;

    int n_cmp  = 0;
    int n_fail = 0;

    pads_out_seq #(.NCH(9), .GROUP(2), .STAGGER_CYC(4), .TEST_DIV(8), .RESET_VAL(9'h000)) u_dut (
        .clk(clk), .rst(rst), .core_out(core_out), .mode(mode), .force_val(force_val),
        .pad_i(pad_a), .en_mask(en_a), .seq_done(done_a), .test_pos(tp_a));

    pads_out_seq #(.NCH(9), .GROUP(2), .STAGGER_CYC(4), .TEST_DIV(8), .RESET_VAL(9'h155)) u_rv (
        .clk(clk), .rst(rst), .core_out(core_out), .mode(mode_rv), .force_val(force_rv),
        .pad_i(pad_r), .en_mask(en_r), .seq_done(done_r), .test_pos(tp_r));

    pads_out_seq #(.NCH(9), .GROUP(9), .STAGGER_CYC(1), .TEST_DIV(8), .RESET_VAL(9'h000)) u_one (
        .clk(clk), .rst(rst), .core_out(core_out), .mode(2'd0), .force_val(9'h000),
        .pad_i(pad_o), .en_mask(en_o), .seq_done(done_o), .test_pos(tp_o));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] m;
        logic [8:0] core;
        logic [8:0] frc;
        logic [8:0] exp_pad;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One rising edge, then settle to the falling edge for sampling/driving
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Expected enable mask after edge e for GROUP=2, STAGGER_CYC=4, NCH=9
    function automatic logic [8:0] exp_mask(input int e);
        int n;
        logic [31:0] m;
        n = (e / 4) * 2;
        if (n > 9) n = 9;
        m = (32'd1 << n) - 32'd1;
        return m[8:0];
    endfunction

    initial begin
        vec_t vt[6];
        logic [8:0] em;
        logic [31:0] w;

        vt[0] = '{2'd0, 9'h0A5, 9'h000, 9'h0A5};
        vt[1] = '{2'd0, 9'h15A, 9'h000, 9'h15A};
        vt[2] = '{2'd1, 9'h000, 9'h000, 9'h15A};
        vt[3] = '{2'd3, 9'h000, 9'h0F0, 9'h0F0};
        vt[4] = '{2'd1, 9'h1FF, 9'h000, 9'h0F0};
        vt[5] = '{2'd0, 9'h000, 9'h1FF, 9'h000};

        rst       = 1'b1;
        core_out  = 9'h1FF;
        mode      = 2'd0;
        force_val = 9'h000;
        mode_rv   = 2'd3;
        force_rv  = 9'h1FF;
        repeat (2) @(negedge clk);

        check("rst_pad",   32'(pad_a),  32'h000);
        check("rst_en",    32'(en_a),   32'h000);
        check("rst_done",  32'(done_a), 32'h0);
        check("rst_tp",    32'(tp_a),   32'h0);
        check("rst_rv_pad", 32'(pad_r), 32'h155);
        check("rst_rv_tp", 32'(tp_r),   32'h0);
        check("rst_one_en", 32'(en_o),  32'h000);
        check("rst_one_tp", 32'(tp_o),  32'h0);
        rst = 1'b0;

        // Stagger bring-up, with the RESET_VAL=0x155 instance forcing all ones
        for (int e = 1; e <= 20; e++) begin
            step();
            em = exp_mask(e);
            check("stag_en",   32'(en_a),   32'(em));
            check("stag_pad",  32'(pad_a),  32'(em));
            check("stag_done", 32'(done_a), (e >= 20) ? 32'h1 : 32'h0);
            check("force_pad", 32'(pad_r),  32'(em | (~em & 9'h155)));
            check("force_en",  32'(en_r),   32'(em));
            if (e == 1) begin
                check("one_en",   32'(en_o),   32'h1FF);
                check("one_done", 32'(done_o), 32'h1);
                check("one_pad",  32'(pad_o),  32'h1FF);
            end
        end
        check("force_done", 32'(done_r), 32'h1);

        // RUN: latency, hold and force vectors, one edge each
        for (int i = 0; i < 6; i++) begin
            mode      = vt[i].m;
            core_out  = vt[i].core;
            force_val = vt[i].frc;
            step();
            check($sformatf("vec%0d_pad", i), 32'(pad_a), 32'(vt[i].exp_pad));
        end
        check("run_en_stable", 32'(en_a), 32'h1FF);

        // Walking one: 8 cycles per position, wraps after 72
        mode = 2'd2;
        for (int i = 1; i <= 80; i++) begin
            step();
            w = 32'd1 << (((i - 1) / 8) % 9);
            check($sformatf("walk%0d_pad", i), 32'(pad_a), w);
            check($sformatf("walk%0d_tp", i),  32'(tp_a),  32'((i / 8) % 9));
        end
        mode = 2'd0;
        step();
        check("walk_exit_tp",  32'(tp_a),  32'h0);
        check("walk_exit_pad", 32'(pad_a), 32'h000);
        mode = 2'd2;
        step();
        check("walk_restart_pad", 32'(pad_a), 32'h001);
        check("walk_restart_tp",  32'(tp_a),  32'h0);

        // Async reset from RUN, then again mid-SEQ at edge 10
        mode     = 2'd0;
        core_out = 9'h1FF;
        #1 rst = 1'b1;
        #1;
        check("rrun_pad",  32'(pad_a),  32'h000);
        check("rrun_en",   32'(en_a),   32'h000);
        check("rrun_done", 32'(done_a), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int e = 1; e <= 10; e++) step();
        check("pre_rst_en",    32'(en_a),  32'h00F);
        check("pre_rst_rvpad", 32'(pad_r), 32'h15F);
        #1 rst = 1'b1;
        #1;
        check("rseq_pad",   32'(pad_a),  32'h000);
        check("rseq_en",    32'(en_a),   32'h000);
        check("rseq_done",  32'(done_a), 32'h0);
        check("rseq_rvpad", 32'(pad_r),  32'h155);
        check("rseq_one",   32'(en_o),   32'h000);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("restart_one_en", 32'(en_o), 32'h1FF);
        step();
        step();
        check("restart_e3_en", 32'(en_a), 32'h000);
        step();
        check("restart_e4_en",  32'(en_a),  32'h003);
        check("restart_e4_pad", 32'(pad_a), 32'h003);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pads_out_seq.md
Name: pads_out_seq

Overview:
Parametrised output-pad front end placed between the core and the output pad cells (LEDs, SPI, UART, boot status).
- Registers every core output once before the pad.
- Enables channels in staggered groups after reset to limit simultaneous switching output.
- Provides hold, force and walking-one pad-test modes for bring-up and board test.
- Drives the pad cell I pins; the pad cells themselves are instantiated outside this block.

Parameters:
NCH, 9, number of output channels (1..32)
GROUP, 2, channels enabled per stagger step (1..NCH)
STAGGER_CYC, 4, clock cycles between stagger steps (>=1)
TEST_DIV, 8, clock cycles per walking-one position (>=1)
RESET_VAL, {NCH{1'b0}}, safe level driven on a channel while it is disabled

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
core_out  input  NCH  functional output values from core
mode  input  2  0=functional, 1=hold, 2=walk test, 3=force
force_val  input  NCH  values driven in force mode
pad_i  output  NCH  registered values to pad cell I pins
en_mask  output  NCH  per-channel enable status (1=channel live)
seq_done  output  1  all channels enabled
test_pos  output  max(1,$clog2(NCH))  current walking-one channel index

Behaviour:
- One clock, clk. rst is asynchronous and active-high: assertion immediately forces reset values; deassertion is synchronised by the integrator.
- Reset values:
  - pad_i=RESET_VAL, en_mask=0, seq_done=0, test_pos=0.
  - Stagger counter=0, step counter=0, walk divider=0.
- Edge numbering: edge 1 is the first rising clk edge with rst low.
- FSM states:
  - SEQ (entered on reset): stagger counter counts 0..STAGGER_CYC-1. On the edge where it wraps, the next GROUP channels (LSB first) are set in en_mask.
  - The last step sets only the remaining NCH mod GROUP channels when NCH is not a multiple of GROUP.
  - Steps = ceil(NCH/GROUP). Step k (1-based) completes on edge k*STAGGER_CYC.
  - SEQ->RUN on the edge that sets the final channels; seq_done=1 on that same edge.
  - RUN: en_mask all ones and stable, seq_done=1. RUN is left only by rst.
- Output register, every edge, per channel c:
  - Next en_mask[c]=0: pad_i[c] <= RESET_VAL[c].
  - Otherwise by mode:
    - 0: pad_i[c] <= core_out[c].
    - 1: pad_i[c] holds its value. A channel enabled while in hold captures RESET_VAL[c].
    - 2: pad_i[c] <= (c==test_pos).
    - 3: pad_i[c] <= force_val[c].
  - A channel's pad_i changes from its safe level on the same edge its en_mask bit sets; "next en_mask" is the mask value being written on that edge.
- Latency: core_out/force_val -> pad_i is exactly 1 clk. A mode change takes effect on the first edge sampling the new mode.
- Walk test:
  - While mode==2, the walk divider counts 0..TEST_DIV-1. On its wrap, test_pos increments, wrapping NCH-1 -> 0.
  - On any edge where mode!=2, divider=0 and test_pos=0. Entering walk mode therefore always starts at channel 0 and dwells TEST_DIV cycles per position.
  - Walk is active in both SEQ and RUN, masked by en_mask.
- Boundaries:
  - NCH=1: test_pos is constant 0.
  - GROUP=NCH: single step; seq_done at edge STAGGER_CYC.
  - STAGGER_CYC=1: one step per edge.
  - Reset mid-SEQ or mid-RUN: all outputs return to reset values immediately and the sequence restarts from step 0.
  - Mode and data inputs are ignored for disabled channels.

Test Plan:
- Stagger: NCH=9, GROUP=2, STAGGER_CYC=4, mode=0, core_out=9'h1FF, RESET_VAL=0 -> en_mask 0x003@edge4, 0x00F@8, 0x03F@12, 0x0FF@16, 0x1FF@20; seq_done 0 before edge 20, 1 from edge 20; pad_i tracks en_mask.
- Latency: in RUN, mode=0, core_out toggles 0x0A5->0x15A at edge N -> pad_i=0x15A from edge N+1; mode=1 then core_out=0x000 -> pad_i stays 0x15A.
- Walk: in RUN, mode=2, TEST_DIV=8, NCH=9 -> pad_i=0x001 for 8 cycles, then 0x002, ..., 0x100, then wraps to 0x001 after 72 cycles; mode back to 0 then 2 -> restarts at 0x001.
- Force during SEQ: mode=3, force_val=0x1FF, RESET_VAL=0x155 -> disabled channels show 0x155 bits, enabled show 1; at edge 20 pad_i=0x1FF.
- Reset mid-operation: assert rst at edge 10 asynchronously, mid-cycle -> pad_i=RESET_VAL, en_mask=0, seq_done=0 immediately; after release, first group enables at edge 4 again.
- Corner: GROUP=NCH=9, STAGGER_CYC=1 -> en_mask=0x1FF and seq_done=1 at edge 1.
